m68k_bus_initiator: RTL and testbench

M68K_BUS_INITIATOR -- requirements
Module: m68k_bus_initiator

---
 rtl/m68k_bus_pkg.sv | 21 ++
 rtl/parallel_synchronizer.sv | 28 ++
 rtl/m68k_bus_initiator.sv | 182 ++++++++++++++++++
 tb/tb_m68k_bus_initiator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000-style bus initiator: FSM state encoding
// and the termination status codes reported alongside done.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_STROBE  = 3'd2,
    S_WAIT    = 3'd3,
    S_LATCH   = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK      = 2'b00;
  localparam status_t ST_BERR    = 2'b01;
  localparam status_t ST_TIMEOUT = 2'b10;
  localparam status_t ST_INVALID = 2'b11;

endpackage

// File: rtl/parallel_synchronizer.sv
// Two-flop synchronizer applied bitwise to a bus of independent async inputs.
// Reset is synchronous; RESET_VAL is the inactive level of the inputs.
module parallel_synchronizer #(
  parameter int               WIDTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/m68k_bus_initiator.sv
// Single-transfer 68000-style bus initiator: runs one read or write cycle per
// accepted request and reports its termination status with a done pulse.
module m68k_bus_initiator
  import m68k_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic        req_rw_n,
  input  logic [22:0] req_addr,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic [1:0]  status,
  output logic [15:0] rdata,
  output logic        as_n,
  output logic        uds_n,
  output logic        lds_n,
  output logic        rw_n,
  output logic [22:0] addr_out,
  output logic [15:0] data_out,
  output logic        data_oe,
  input  logic        dtack_n,
  input  logic        berr_n,
  input  logic [15:0] data_in,
  output logic [2:0]  dbg_state
);

  // Handshake: a request is taken on a rising edge where start && ready;
  // start while ready is low is dropped, never queued.

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [22:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    be_q, be_d;
  logic          rw_q, rw_d;
  status_t       status_q, status_d;
  logic [15:0]   rdata_q, rdata_d;

  logic [1:0]    resp_sync;
  logic          berr_s;
  logic          dtack_s;
  logic          cnt_last;
  logic          strobing;

  parallel_synchronizer #(
    .WIDTH     (2),
    .RESET_VAL (2'b11)
  ) u_sync (
    .clk     (clock),
    .reset_n (~reset),
    .d       ({berr_n, dtack_n}),
    .q       (resp_sync)
  );

  assign berr_s   = resp_sync[1];
  assign dtack_s  = resp_sync[0];
  assign cnt_last = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rw_q     <= 1'b1;
      status_q <= ST_OK;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rw_q     <= rw_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  // The counter times WAIT, then is reused to bound the RELEASE hold-off;
  // it reads zero only on the first RELEASE cycle, which is where done fires.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rw_d     = rw_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          addr_d  = req_addr;
          rw_d    = req_rw_n;
          be_d    = req_be;
          wdata_d = req_wdata;
          if (req_be == 2'b00) begin
            state_d  = S_RELEASE;
            status_d = ST_INVALID;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: state_d = S_STROBE;
      S_STROBE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!berr_s) begin
          state_d  = S_RELEASE;
          status_d = ST_BERR;
          cnt_d    = '0;
        end else if (!dtack_s) begin
          cnt_d = '0;
          if (rw_q) begin
            state_d = S_LATCH;
          end else begin
            state_d  = S_RELEASE;
            status_d = ST_OK;
          end
        end else if (cnt_last) begin
          state_d  = S_RELEASE;
          status_d = ST_TIMEOUT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        state_d  = S_RELEASE;
        status_d = ST_OK;
        rdata_d  = data_in;
        cnt_d    = '0;
      end
      S_RELEASE: begin
        if ((dtack_s && berr_s) || cnt_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    strobing  = (state_q == S_STROBE) || (state_q == S_WAIT) || (state_q == S_LATCH);
    ready     = (state_q == S_IDLE);
    as_n      = ~strobing;
    uds_n     = ~(strobing && be_q[1]);
    lds_n     = ~(strobing && be_q[0]);
    rw_n      = (state_q == S_IDLE) ? 1'b1 : rw_q;
    done      = (state_q == S_RELEASE) && (cnt_q == '0);
    // be_q == 0 marks the INVALID path, which never drove the bus.
    data_oe   = ~rw_q && ((state_q == S_STROBE) || (state_q == S_WAIT) ||
                ((state_q == S_RELEASE) && (cnt_q == '0) && (be_q != 2'b00)));
    addr_out  = addr_q;
    data_out  = wdata_q;
    status    = status_q;
    rdata     = rdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// Self-checking bench for m68k_bus_initiator: directed and random transfers
// against a responder model, with a transaction-level reference model.
module tb_m68k_bus_initiator;
  import m68k_bus_pkg::*;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic        req_rw_n;
  logic [22:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        done;
  logic [1:0]  status;
  logic [15:0] rdata;
  logic        as_n, uds_n, lds_n, rw_n;
  logic [22:0] addr_out;
  logic [15:0] data_out;
  logic        data_oe;
  logic        dtack_n, berr_n;
  logic [15:0] data_in;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q[$];
  logic [15:0] model_rdata = '0;

  // Responder behaviour: 0 none, 1 dtack, 2 berr, 3 both; asserted dly cycles into as_n low.
  int          resp_mode  = 0;
  int          resp_delay = 1;
  logic [15:0] resp_data  = '0;
  int          as_cnt     = 0;

  m68k_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ready     (ready),
    .req_rw_n  (req_rw_n),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .done      (done),
    .status    (status),
    .rdata     (rdata),
    .as_n      (as_n),
    .uds_n     (uds_n),
    .lds_n     (lds_n),
    .rw_n      (rw_n),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .dtack_n   (dtack_n),
    .berr_n    (berr_n),
    .data_in   (data_in),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Responder model
  initial begin
    dtack_n = 1'b1;
    berr_n  = 1'b1;
    data_in = '0;
    forever begin
      @(negedge clock);
      if (as_n === 1'b0) begin
        as_cnt++;
        if (as_cnt == resp_delay) begin
          if (resp_mode == 1 || resp_mode == 3) dtack_n = 1'b0;
          if (resp_mode >= 2) berr_n = 1'b0;
          data_in = resp_data;
        end
      end else begin
        as_cnt  = 0;
        dtack_n = 1'b1;
        berr_n  = 1'b1;
        data_in = 16'($urandom);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic rw, input logic [1:0] be, input logic [22:0] addr,
                         input logic [15:0] wd, input int mode, input int dly,
                         input logic [15:0] rd, input bit poke);
    status_t     es;
    logic [17:0] e;
    int          exp_done_n, n, done_n, fall_n, as_low, oe_cyc;
    bit          got, uds_seen, lds_seen, addr_bad, rw_bad, dout_bad, extra;
    logic [2:0]  strobes_at_done;
    logic [1:0]  st_obs;
    logic [15:0] rd_obs;

    // Reference model: outcome and cycle of done from the bus rules.
    if (be == 2'b00)    es = ST_INVALID;
    else if (mode >= 2) es = ST_BERR;
    else if (mode == 1) es = ST_OK;
    else                es = ST_TIMEOUT;
    if (es == ST_OK && rw) model_rdata = rd;
    exp_q.push_back({es, model_rdata});
    case (es)
      ST_INVALID: exp_done_n = 1;
      ST_OK:      exp_done_n = dly + (rw ? 5 : 4);
      ST_BERR:    exp_done_n = dly + 4;
      default:    exp_done_n = 2 + TO + 1;
    endcase

    resp_mode  = mode;
    resp_delay = dly;
    resp_data  = rd;

    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_start", ready, 1);

    @(posedge clock); #1;
    start = 1'b1; req_rw_n = rw; req_addr = addr; req_be = be; req_wdata = wd;
    @(posedge clock); #1;
    start = 1'b0;
    req_rw_n = 1'($urandom); req_addr = 23'($urandom);
    req_be = 2'($urandom); req_wdata = 16'($urandom);

    got = 0; done_n = -1; fall_n = -1; as_low = 0; oe_cyc = 0;
    uds_seen = 0; lds_seen = 0; addr_bad = 0; rw_bad = 0; dout_bad = 0;
    strobes_at_done = 'x; st_obs = 'x; rd_obs = 'x;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clock);
      if (poke) start = (i == 4);
      if (as_n === 1'b0) begin
        as_low++;
        if (fall_n < 0) fall_n = i;
        if (addr_out !== addr) addr_bad = 1;
        if (rw_n !== rw) rw_bad = 1;
      end
      if (uds_n === 1'b0) uds_seen = 1;
      if (lds_n === 1'b0) lds_seen = 1;
      if (data_oe === 1'b1) begin
        oe_cyc++;
        if (data_out !== wd) dout_bad = 1;
      end
      if (done === 1'b1) begin
        got = 1;
        done_n = i;
        st_obs = status;
        rd_obs = rdata;
        strobes_at_done = {as_n, uds_n, lds_n};
      end
    end
    start = 1'b0;

    check("done_seen", got, 1);
    e = exp_q.pop_front();
    check("status", st_obs, e[17:16]);
    check("rdata", rd_obs, e[15:0]);
    check("done_latency", done_n, exp_done_n);
    check("as_activity", as_low > 0, be != 2'b00);
    check("uds_low", uds_seen, be[1]);
    check("lds_low", lds_seen, be[0]);
    check("addr_stable", addr_bad, 0);
    check("rw_stable", rw_bad, 0);
    check("data_out", dout_bad, 0);
    check("oe_cycles", oe_cyc, (!rw && be != 2'b00) ? as_low + 1 : 0);
    check("strobes_at_done", strobes_at_done, 3'b111);

    // After done: no second pulse, no bus activity, back to ready in bounded time.
    extra = 0;
    n = 0;
    while (n < TO + 6) begin
      @(negedge clock);
      n++;
      if (done === 1'b1 || as_n === 1'b0) extra = 1;
      if (ready === 1'b1) break;
    end
    check("ready_after", ready, 1);
    repeat (3) begin
      @(negedge clock);
      if (done === 1'b1 || as_n === 1'b0) extra = 1;
    end
    check("quiet_after_done", extra, 0);
  endtask

  initial begin
    bit          rw;
    logic [1:0]  be;
    int          mode;
    bit          quiet_bad;

    reset = 1'b1; start = 1'b0; req_rw_n = 1'b1; req_addr = '0; req_be = '0; req_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_strobes", {as_n, uds_n, lds_n, rw_n}, 4'hF);
    check("reset_oe_done", {data_oe, done}, 2'b00);
    check("reset_status", status, ST_OK);
    check("reset_rdata", rdata, 16'h0);
    check("reset_addr_data", {addr_out, data_out}, 39'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("reset_ready", ready, 1);

    // Directed transfers
    run_txn(1'b1, 2'b11, 23'h123456, 16'h0000, 1, 3, 16'hBEEF, 1'b0);
    run_txn(1'b0, 2'b01, 23'h00ABCD, 16'h00A5, 1, 2, 16'h0000, 1'b0);
    run_txn(1'b1, 2'b10, 23'h7FFFFF, 16'h0000, 0, 1, 16'h5555, 1'b1);
    run_txn(1'b1, 2'b11, 23'h000001, 16'h0000, 3, 4, 16'h1234, 1'b0);
    run_txn(1'b0, 2'b00, 23'h012345, 16'hFFFF, 1, 2, 16'h0000, 1'b0);
    run_txn(1'b0, 2'b11, 23'h000000, 16'hC3C3, 2, 8, 16'h0000, 1'b0);

    // Random transfers
    for (int k = 0; k < 24; k++) begin
      rw   = 1'($urandom_range(0, 1));
      be   = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      mode = $urandom_range(0, 3);
      run_txn(rw, be, 23'($urandom), 16'($urandom), mode, $urandom_range(1, 8),
              16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset while waiting for a responder that never answers
    resp_mode = 0;
    @(posedge clock); #1;
    start = 1'b1; req_rw_n = 1'b0; req_addr = 23'h2AAAAA; req_be = 2'b11; req_wdata = 16'h6789;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    check("pre_reset_in_wait", {as_n, uds_n, lds_n, data_oe}, 4'b0001);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("reset_wait_strobes", {as_n, uds_n, lds_n}, 3'b111);
    check("reset_wait_oe", data_oe, 0);
    check("reset_wait_done", done, 0);
    check("reset_wait_status", status, ST_OK);
    check("reset_wait_rdata", rdata, 16'h0);
    reset = 1'b0;
    model_rdata = '0;
    exp_q.delete();
    @(posedge clock); #1;
    check("reset_wait_ready", ready, 1);
    quiet_bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (done === 1'b1 || as_n === 1'b0) quiet_bad = 1;
    end
    check("reset_wait_quiet", quiet_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
